// File: rtl/p2s_arb.sv
// p2s_arb: round-robin arbiter feeding one parallel word at a time
// into a downstream p2s stage with a valid/ready handshake.
//
// Ports:
//   clk, rstn      clock, async active-low reset
//   req_data       M packed words, requester i in [i*N +: N]
//   req_valid      per-requester word pending
//   req_ready      one-hot accept strobe (IDLE only)
//   p_data         captured word offered downstream
//   p_valid        p_data valid (HOLD state)
//   p_ready        downstream accepts p_data
//   grant_id       index of requester owning p_data
//   word_cnt       words handed downstream, wrapping
module p2s_arb #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int IW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [M*N-1:0] req_data,
  input  logic [M-1:0]   req_valid,
  output logic [M-1:0]   req_ready,
  output logic [N-1:0]   p_data,
  output logic           p_valid,
  input  logic           p_ready,
  output logic [IW-1:0]  grant_id,
  output logic [15:0]    word_cnt
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [N-1:0]  win_word;
  logic          take;
  logic          done;

  // Scan from ptr+M-1 down to ptr; the last hit is the
  // first valid requester in round-robin order from ptr.
  always_comb begin : pick
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = M - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % M;
      if (req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  assign win_word = req_data[int'(win_idx)*N +: N];

  always_comb begin : fsm
    state_n = state;
    take    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n = HOLD;
          take    = 1'b1;
        end
      end
      HOLD: begin
        if (p_ready) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ptr_nxt = (grant_id == IW'(M - 1)) ?
                   '0 : grant_id + 1'b1;

  // rstn gates the strobe so it is zero throughout reset,
  // even while requesters keep req_valid asserted.
  assign req_ready = (rstn && state == IDLE && win_found) ?
                     (M'(1) << win_idx) : '0;

  assign p_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      p_data   <= '0;
      grant_id <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        p_data   <= win_word;
        grant_id <= win_idx;
      end
      if (done) begin
        ptr      <= ptr_nxt;
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_p2s_arb.sv
// tb_p2s_arb: directed scenarios plus randomized traffic
// compared against a transaction-level arbiter model.
module tb_p2s_arb;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int IW = $clog2(M);

  logic           clk = 1'b0;
  logic           rstn;
  logic [M*N-1:0] req_data;
  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_ready;
  logic [N-1:0]   p_data;
  logic           p_valid;
  logic           p_ready;
  logic [IW-1:0]  grant_id;
  logic [15:0]    word_cnt;

  int tests = 0;
  int fails = 0;

  // reference model: a held word plus a fairness pointer
  bit         m_hold;
  int         m_ptr;
  int         m_gid;
  int         m_cnt;
  logic [N-1:0] m_data;

  p2s_arb #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .grant_id  (grant_id),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < M; k++) begin
      int j;
      j = (m_ptr + k) % M;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = 0;
    m_ptr  = 0;
    m_gid  = 0;
    m_cnt  = 0;
    m_data = '0;
  endtask

  task automatic check_all();
    int w;
    logic [M-1:0] rr;
    w  = winner();
    rr = '0;
    if (!m_hold && w >= 0) rr[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(rr));
    chk("p_valid",   32'(p_valid),   32'(m_hold));
    chk("p_data",    32'(p_data),    32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    chk("word_cnt",  32'(word_cnt),  32'(m_cnt & 16'hFFFF));
  endtask

  // compare settled outputs, then clock once and advance model
  task automatic tick();
    int w;
    #1;
    check_all();
    w = winner();
    @(posedge clk);
    if (!m_hold) begin
      if (w >= 0) begin
        m_hold = 1;
        m_gid  = w;
        m_data = req_data[w*N +: N];
      end
    end else if (p_ready) begin
      m_hold = 0;
      m_ptr  = (m_gid + 1) % M;
      m_cnt  = (m_cnt + 1) & 16'hFFFF;
    end
    #1;
  endtask

  task automatic async_reset(input string tag);
    rstn = 1'b0;
    #1;
    chk({tag, "_rr"},  32'(req_ready), 32'h0);
    chk({tag, "_pv"},  32'(p_valid),   32'h0);
    chk({tag, "_pd"},  32'(p_data),    32'h0);
    chk({tag, "_gid"}, 32'(grant_id),  32'h0);
    chk({tag, "_cnt"}, 32'(word_cnt),  32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    req_data  = '0;
    req_valid = 4'b1111;
    p_ready   = 1'b0;
    model_reset();
    #2;
    chk("rst_rr",  32'(req_ready), 32'h0);
    chk("rst_pv",  32'(p_valid),   32'h0);
    chk("rst_cnt", 32'(word_cnt),  32'h0);
    @(posedge clk);
    #1;
    rstn      = 1'b1;
    req_valid = '0;

    // single request
    req_data  = 32'h003E_0000;
    req_valid = 4'b0100;
    p_ready   = 1'b1;
    #1;
    chk("single_rr", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_pv",  32'(p_valid),  32'h1);
    chk("single_pd",  32'(p_data),   32'h3E);
    chk("single_gid", 32'(grant_id), 32'h2);
    tick();
    chk("single_idle", 32'(p_valid),  32'h0);
    chk("single_cnt",  32'(word_cnt), 32'h1);
    tick();

    // mid-run reset while a request is pending
    req_valid = 4'b1111;
    async_reset("midrst");

    // fairness from ptr 0
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    p_ready   = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("fair_gid", 32'(grant_id), 32'(g % M));
      chk("fair_pd",  32'(p_data),   32'(8'h10 + g % M));
      tick();
    end

    // backpressure: ptr is now 1 after the last grant of 0
    req_data  = 32'h0000_5200;
    req_valid = 4'b0010;
    p_ready   = 1'b0;
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      chk("bp_pv",  32'(p_valid),   32'h1);
      chk("bp_pd",  32'(p_data),    32'h52);
      chk("bp_rr",  32'(req_ready), 32'h0);
      chk("bp_cnt", 32'(word_cnt),  32'd5);
      tick();
    end
    p_ready   = 1'b1;
    req_valid = 4'b1010;
    tick();
    chk("bp_cnt_inc", 32'(word_cnt), 32'd6);

    // last grant 1 -> ptr 2; 4'b1010 skips to 3 then 1
    tick();
    chk("skip_gid0", 32'(grant_id), 32'h3);
    tick();
    tick();
    chk("skip_gid1", 32'(grant_id), 32'h1);
    tick();

    // reset during HOLD discards the word
    p_ready   = 1'b0;
    req_valid = 4'b0100;
    tick();
    chk("hrst_pv_pre", 32'(p_valid), 32'h1);
    async_reset("hrst");
    req_valid = 4'b1111;
    tick();
    chk("hrst_gid", 32'(grant_id), 32'h0);
    chk("hrst_cnt", 32'(word_cnt), 32'h0);
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      req_valid = M'($urandom);
      req_data  = {$urandom};
      p_ready   = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p2s_arb.md
P2S_ARB -- requirements
Module: p2s_arb

Interface
REQ-001 Parameter N, default 8: width of one parallel word.
REQ-002 Parameter M, default 4: number of requesters, M >= 2; IW = $clog2(M).
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-005 Port req_data, input, M*N: requester i word in bits [i*N +: N].
REQ-006 Port req_valid, input, M: requester i has a word pending.
REQ-007 Port req_ready, output, M: arbiter accepts requester i's word this cycle.
REQ-008 Port p_data, output, N: word offered to the downstream p2s parallel input.
REQ-009 Port p_valid, output, 1: p_data is valid.
REQ-010 Port p_ready, input, 1: downstream p2s accepts p_data.
REQ-011 Port grant_id, output, IW: index of the requester whose word is on p_data.
REQ-012 Port word_cnt, output, 16: count of words handed downstream; wraps 16'hFFFF -> 0.

Function
REQ-013 The FSM SHALL have two states, IDLE and HOLD, with a registered round-robin pointer ptr (IW bits).
REQ-014 In IDLE, the winner SHALL be the first i with req_valid[i]=1, searching i = ptr, ptr+1, ... mod M.
REQ-015 In IDLE, req_ready SHALL be one-hot on the winner, combinationally derived from req_valid, or all zero if no req_valid bit is set.
REQ-016 In HOLD, req_ready SHALL be all zero.
REQ-017 On a clock edge in IDLE with a winner, the block SHALL register the winner's word into p_data, the winner's index into grant_id, and enter HOLD.
REQ-018 p_valid SHALL equal (state == HOLD); latency from accepted request to p_valid is exactly 1 cycle.
REQ-019 In HOLD, p_data and grant_id SHALL remain stable until a clock edge with p_ready=1.
REQ-020 On a HOLD edge with p_ready=1, the block SHALL:
- return to IDLE;
- set ptr = (grant_id+1) mod M;
- increment word_cnt by 1.
REQ-021 In IDLE, p_ready SHALL be ignored.
REQ-022 A requester dropping req_valid while not granted SHALL have no effect on state or ptr.
REQ-023 Maximum throughput SHALL be one word per 2 cycles (IDLE, HOLD); no IDLE-bypass path.
REQ-024 When ptr wraps from M-1, it SHALL go to 0.
REQ-025 req_data bits of non-winning requesters SHALL never reach p_data.

Reset
REQ-026 While rstn=0, regardless of clock, the outputs and state SHALL be:
- state = IDLE, ptr = 0;
- p_valid = 0, p_data = 0, grant_id = 0, word_cnt = 0;
- req_ready = 0.
REQ-027 Reset asserted in HOLD SHALL discard the captured word, without incrementing word_cnt.
REQ-028 After rstn rises, the first arbitration SHALL start from ptr = 0.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- Reset: drive rstn=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.
- Single request: req_valid=4'b0100, word2=8'h3E, p_ready=1 -> req_ready=4'b0100 for 1 cycle; next cycle p_valid=1, p_data=8'h3E, grant_id=2; then IDLE, ptr=3, word_cnt=1.
- Fairness: all four req_valid held high, words 8'h10..8'h13, p_ready=1 -> grant_id sequence 0,1,2,3,0; p_data 10,11,12,13,10.
- Backpressure: p_ready=0 for 5 cycles in HOLD with p_data=8'h52 -> p_valid=1 and p_data=8'h52 held stable; req_ready=0 throughout; word_cnt unchanged until p_ready=1.
- Skip on pointer: last grant=1 (ptr=2), req_valid=4'b1010 -> next grant_id=3, then 1.
- Reset during HOLD: p_valid drops asynchronously; after release, req_valid=4'b1111 -> grant_id=0.
